// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result handshake bundle between an operand source and serial_adder
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a_in, b_in, cin,
        input  busy, done, sum_out, cout, ovf
    );

    modport slave (
        input  start, a_in, b_in, cin,
        output busy, done, sum_out, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one full-adder slice per clock, LSB first
// Optional signed-overflow flag built only when SERIAL_ADDER_OVF_EN is defined.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MSB_BIT = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             s_bit, c_next, last_bit;

    assign s_bit    = a_q[0] ^ b_q[0] ^ c_q;
    assign c_next   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == SHIFT);
        bus.done = (state_q == DONE);
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        if (state_q == IDLE && bus.start) begin
            a_d   = bus.a_in;
            b_d   = bus.b_in;
            c_d   = bus.cin;
            sr_d  = '0;
            cnt_d = '0;
        end else if (state_q == SHIFT) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = c_next;
            sr_d  = (sr_q >> 1) | (s_bit ? MSB_BIT : '0);
            cnt_d = cnt_q + CNT_W'(1);
            // Result registers only move on the final slice so sum_out stays stable while shifting.
            if (last_bit) begin
                sum_d  = sr_d;
                cout_d = c_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            sr_q   <= '0;
            cnt_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign bus.sum_out = sum_q;
    assign bus.cout    = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // On the last slice c_q is the carry into the MSB and c_next the carry out of it.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == SHIFT && last_bit) ovf_d = c_q ^ c_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances)
module tb_serial_adder;
    localparam int W = 8;
`ifdef SERIAL_ADDER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Signed overflow from operand/result signs, independent of how the carries are formed.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         output logic [7:0] s, output logic co, output logic ov);
        logic [8:0] t;
        t  = {1'b0, a} + {1'b0, b} + {8'b0, ci};
        s  = t[7:0];
        co = t[8];
        ov = OVF_EN && (a[7] == b[7]) && (s[7] != a[7]);
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic ci);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        bus.cin   = ci;
    endtask

    // Called at a negedge with start already driven; lat counts edges from the accepting edge
    // (inclusive) up to the cycle where done is seen.
    task automatic wait_done(output int lat, output int busy_n);
        bit seen = 1'b0;
        lat    = 0;
        busy_n = 0;
        @(posedge clk);
        lat = 1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_n++;
            @(posedge clk);
            lat++;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          output int lat, output int busy_n);
        @(negedge clk);
        start_op(a, b, ci);
        wait_done(lat, busy_n);
    endtask

    initial begin
        vec_t       tbl[6];
        int         lat, busy_n, d0;
        logic [7:0] ra, rb, es;
        logic       rc, eco, eov;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        bus.start  = 1'b0; bus.a_in  = '0; bus.b_in  = '0; bus.cin  = 1'b0;
        bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.cin = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sum", bus.sum_out, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_add(tbl[i].a, tbl[i].b, tbl[i].ci, lat, busy_n);
            check($sformatf("tbl%0d_sum", i), bus.sum_out, tbl[i].s);
            check($sformatf("tbl%0d_cout", i), bus.cout, tbl[i].co);
            check($sformatf("tbl%0d_ovf", i), bus.ovf, tbl[i].ov & OVF_EN);
            check($sformatf("tbl%0d_latency", i), lat, W + 1);
            check($sformatf("tbl%0d_busy_cycles", i), busy_n, W);
        end

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom_range(0, 1));
            model(ra, rb, rc, es, eco, eov);
            do_add(ra, rb, rc, lat, busy_n);
            check($sformatf("rnd%0d_sum", i), bus.sum_out, es);
            check($sformatf("rnd%0d_cout", i), bus.cout, eco);
            check($sformatf("rnd%0d_ovf", i), bus.ovf, eov);
        end

        // start during SHIFT and during DONE must be ignored
        @(posedge clk); #1;
        d0 = done_cnt;
        @(negedge clk);
        start_op(8'h10, 8'h20, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        start_op(8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        for (int n = 0; n < 20 && bus.done !== 1'b1; n++) @(negedge clk);
        check("ign_done_seen", bus.done, 1);
        check("ign_sum", bus.sum_out, 8'h30);
        start_op(8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        check("ign_done_start_busy", bus.busy, 0);
        check("ign_sum_held", bus.sum_out, 8'h30);
        start_op(8'h01, 8'h02, 1'b0);
        wait_done(lat, busy_n);
        check("after_done_sum", bus.sum_out, 8'h03);
        check("after_done_lat", lat, W + 1);
        @(posedge clk); #1;
        check("ign_done_count", done_cnt - d0, 2);

        // reset in the middle of an add
        @(negedge clk);
        start_op(8'hAA, 8'h55, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_sum", bus.sum_out, 0);
        check("midrst_cout", bus.cout, 0);
        check("midrst_ovf", bus.ovf, 0);
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_idle", bus.busy, 0);
        do_add(8'h01, 8'h01, 1'b0, lat, busy_n);
        check("postrst_sum", bus.sum_out, 8'h02);

        // WIDTH=1 instance, all operand combinations
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kv;
            logic [1:0] t1;
            bit         seen1;
            kv    = 3'(k);
            t1    = 2'(kv[0]) + 2'(kv[1]) + 2'(kv[2]);
            seen1 = 1'b0;
            @(negedge clk);
            bus1.start = 1'b1;
            bus1.a_in  = kv[0];
            bus1.b_in  = kv[1];
            bus1.cin   = kv[2];
            @(posedge clk);
            lat = 1;
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                bus1.start = 1'b0;
                if (bus1.done === 1'b1) begin
                    seen1 = 1'b1;
                    break;
                end
                @(posedge clk);
                lat++;
            end
            if (!seen1) check("w1_done_timeout", 32'd0, 32'd1);
            check($sformatf("w1_%0d_sum", k), bus1.sum_out, t1[0]);
            check($sformatf("w1_%0d_cout", k), bus1.cout, t1[1]);
            check($sformatf("w1_%0d_latency", k), lat, 2);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
